// File: rtl/ag32gbd_capture_seq.sv
// Camera capture sequencer: exposure timing, 2-bit quantisation and Game Boy tile-layout frame-buffer writes.
// Optional macro AG32GBD_CAPTURE_INVERT_EN enables pixel inversion selected by latched Reg_A001[0].
`timescale 1ns/1ps
module ag32gbd_capture_seq (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        Cam_Capture,
  input  logic [7:0]  Reg_A001,
  input  logic [7:0]  Reg_A002,
  input  logic [7:0]  Reg_A003,
  input  logic        Tick_16us,
  input  logic        Pix_Valid,
  input  logic [7:0]  Pix_Data,
  output logic        Pix_Ready,
  output logic        Fb_Req_Write,
  output logic [11:0] Fb_Addr,
  output logic [7:0]  Fb_Data,
  input  logic        Fb_WriteDone,
  output logic        Sig_CamCaptureFinish
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXPOSE, S_STREAM, S_WR_LO, S_WR_HI, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        cap_q, cap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic        last_q, last_d;
  logic        abort_q, abort_d;
  logic        rdy_q, rdy_d;
  logic        req_q, req_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        fin_q, fin_d;
  logic        inv_q, inv_d;

  logic [1:0]  pix_code;
  logic [7:0]  lo_next, hi_next;
  logic        xfer, frame_end, unused_bits;

`ifdef AG32GBD_CAPTURE_INVERT_EN
  assign pix_code    = inv_q ? ~Pix_Data[7:6] : Pix_Data[7:6];
  assign unused_bits = ^{Reg_A001[7:1], Pix_Data[5:0]};
`else
  assign pix_code    = Pix_Data[7:6];
  assign unused_bits = ^{Reg_A001, Pix_Data[5:0], inv_q};
`endif

  assign lo_next   = {lo_q[6:0], pix_code[0]};
  assign hi_next   = {hi_q[6:0], pix_code[1]};
  assign xfer      = Pix_Valid & rdy_q;
  assign frame_end = (x_q == 7'd127) && (y_q == 7'd111);

  always_comb begin
    state_d = state_q;
    cap_d   = Cam_Capture;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    last_d  = last_q;
    abort_d = abort_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    inv_d   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (Cam_Capture && !cap_q) begin
          state_d = S_EXPOSE;
          cnt_d   = {Reg_A002, Reg_A003};
`ifdef AG32GBD_CAPTURE_INVERT_EN
          inv_d   = Reg_A001[0];
`else
          inv_d   = 1'b0;
`endif
          x_d     = '0;
          y_d     = '0;
          lo_d    = '0;
          hi_d    = '0;
          last_d  = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_EXPOSE: begin
        if (!Cam_Capture)         state_d = S_IDLE;
        else if (cnt_q == 16'd0)  state_d = S_STREAM;
        else if (Tick_16us)       cnt_d   = cnt_q - 16'd1;
      end
      S_STREAM: begin
        if (!Cam_Capture) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          lo_d = lo_next;
          hi_d = hi_next;
          x_d  = x_q + 7'd1;
          if (x_q == 7'd127) y_d = frame_end ? 7'd0 : y_q + 7'd1;
          if (x_q[2:0] == 3'd7) begin
            // Tile layout: {tile row, tile column, line in tile, plane}
            state_d = S_WR_LO;
            req_d   = 1'b1;
            addr_d  = {y_q[6:3], x_q[6:3], y_q[2:0], 1'b0};
            data_d  = lo_next;
            last_d  = frame_end;
          end
        end
      end
      S_WR_LO: begin
        abort_d = abort_q | ~Cam_Capture;
        if (req_q && Fb_WriteDone) begin
          req_d = 1'b0;
          if (abort_d) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
          end else begin
            state_d   = S_WR_HI;
            addr_d[0] = 1'b1;
            data_d    = hi_q;
          end
        end
      end
      S_WR_HI: begin
        abort_d = abort_q | ~Cam_Capture;
        // First WR_HI cycle is the mandatory request gap after the low-plane write
        if (!req_q) begin
          req_d = 1'b1;
        end else if (Fb_WriteDone) begin
          req_d = 1'b0;
          if (abort_d) begin
            state_d = S_IDLE;
            abort_d = 1'b0;
          end else if (last_q) begin
            state_d = S_FINISH;
            cnt_d   = 16'd3;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_FINISH: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_STREAM);
    fin_d = (state_d == S_FINISH);
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q <= S_IDLE;
      cap_q   <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      rdy_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      fin_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      rdy_q   <= rdy_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
      inv_q   <= inv_d;
    end
  end

  assign Pix_Ready            = rdy_q;
  assign Fb_Req_Write         = req_q;
  assign Fb_Addr              = addr_q;
  assign Fb_Data              = data_q;
  assign Sig_CamCaptureFinish = fin_q;

endmodule

// File: doc/ag32gbd_capture_seq.md
AG32GBD_CAPTURE_SEQ -- requirements
Module: ag32gbd_capture_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 sys_clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 sys_resetn  input  1  asynchronous active-low reset.
REQ-004 Cam_Capture  input  1  capture request level, driven from register A000 bit 0.
REQ-005 Reg_A001  input  8  capture options; bit 0 selects invert (see Configuration).
REQ-006 Reg_A002  input  8  exposure count, high byte.
REQ-007 Reg_A003  input  8  exposure count, low byte.
REQ-008 Tick_16us  input  1  one-cycle exposure time-base strobe.
REQ-009 Pix_Valid  input  1  source pixel available.
REQ-010 Pix_Data  input  8  grayscale pixel, raster order, 128 wide x 112 high.
REQ-011 Pix_Ready  output  1  sequencer accepts the pixel this cycle.
REQ-012 Fb_Req_Write  output  1  frame-buffer write request, held until Fb_WriteDone.
REQ-013 Fb_Addr  output  12  frame-buffer byte address, 0..3583.
REQ-014 Fb_Data  output  8  frame-buffer byte.
REQ-015 Fb_WriteDone  input  1  one-cycle write acknowledge.
REQ-016 Sig_CamCaptureFinish  output  1  capture-complete indication.

Function
REQ-017 States: IDLE, EXPOSE, STREAM, WR_LO, WR_HI, FINISH.
REQ-018 IDLE->EXPOSE on a rising edge of Cam_Capture (registered, not level); latches {Reg_A002,Reg_A003} into a 16-bit down-counter and latches Reg_A001[0].
REQ-019 EXPOSE: counter decrements once per Tick_16us; exits to STREAM the cycle after the counter equals 0; latched value 0 goes directly to STREAM on the next cycle.
REQ-020 STREAM: Pix_Ready=1 only in this state; a transfer occurs when Pix_Valid and Pix_Ready are both 1.
REQ-021 Each transferred pixel quantises to 2-bit code v = Pix_Data[7:6]; bit 0 of v shifts into a low-plane byte, bit 1 into a high-plane byte, MSB first (leftmost pixel = bit 7).
REQ-022 After the 8th pixel of a group, STREAM->WR_LO; Pix_Ready=0 until return to STREAM.
REQ-023 Address of the group: x = column of first pixel, y = row; Fb_Addr = ((y>>3)*16 + (x>>3))*16 + (y&7)*2 for the low plane, +1 for the high plane (Game Boy tile layout).
REQ-024 WR_LO asserts Fb_Req_Write with the low-plane byte; on Fb_WriteDone drops request for one cycle, then WR_HI asserts it with the high-plane byte; on Fb_WriteDone returns to STREAM, or to FINISH after pixel (127,111).
REQ-025 Fb_Addr/Fb_Data SHALL be stable while Fb_Req_Write=1; Fb_WriteDone while Fb_Req_Write=0 is ignored.
REQ-026 x wraps 127->0 and increments y; y never exceeds 111 (14336 pixels per frame, 3584 bytes).
REQ-027 FINISH drives Sig_CamCaptureFinish=1 for exactly 4 cycles, then IDLE; a new capture requires a new Cam_Capture rising edge.
REQ-028 Cam_Capture=0 in EXPOSE or STREAM aborts to IDLE with no finish pulse; in WR_LO/WR_HI the pending write completes first, then IDLE.
REQ-029 Pixels presented outside STREAM are not consumed; Pix_Valid with Pix_Ready=0 is ignored.

Reset
REQ-030 On reset all outputs are 0, state IDLE, counters, x, y, plane shifters and the edge-detect register are 0.
REQ-031 Reset mid-capture or mid-write abandons the operation immediately; no finish pulse follows.

Configuration
REQ-032 Macro AG32GBD_CAPTURE_INVERT_EN: defined -> when latched Reg_A001[0]=1, v = ~Pix_Data[7:6]; undefined -> Reg_A001 is ignored and v = Pix_Data[7:6] always.

Verification
REQ-033 A002=0x00,A003=0x03, Cam_Capture rise, Tick every 10 cycles -> STREAM entered after the 3rd tick plus 1 cycle; Pix_Ready=0 before that.
REQ-034 Eight pixels 0xFF,0x00 alternating at (0,0) -> writes addr 0x000 data 0xAA, then addr 0x001 data 0xAA.
REQ-035 First pixel of group at x=8,y=9 -> low-plane address 0x112, high 0x113; last group (120,111) -> 0xDFE/0xDFF.
REQ-036 Full 14336-pixel frame with Fb_WriteDone delayed 5 cycles -> exactly 3584 writes, then Sig_CamCaptureFinish high for 4 cycles.
REQ-037 Cam_Capture dropped mid-STREAM -> IDLE, no finish pulse; dropped during WR_HI -> that write completes, then IDLE.
REQ-038 With AG32GBD_CAPTURE_INVERT_EN defined and A001=0x01, eight 0x00 pixels -> 0xFF,0xFF; macro undefined -> 0x00,0x00.
